// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer-width helpers and the occupancy
// arithmetic used by both the read and write controllers.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_PTR_W  = DEF_ADDR_W + 1;
    localparam int unsigned MAX_PTR_W  = 32;

    typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

    // Pointer difference modulo 2^w; callers narrow the result to w bits.
    function automatic wide_ptr_t ptr_occ(
        input wide_ptr_t   wr,
        input wide_ptr_t   rd,
        input int unsigned w
    );
        wide_ptr_t mask;
        if (w >= MAX_PTR_W) begin
            mask = '1;
        end else begin
            mask = (wide_ptr_t'(1) << w) - wide_ptr_t'(1);
        end
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output skid buffer for the FIFO read side.
// Entry 0 is the head presented to the consumer.
module rd_skid_buf #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head_data,
    output logic         head_valid
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d = din;
                    end else begin
                        e1_d = din;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind the survivor.
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din;
                    end else begin
                        e0_d = din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count      = cnt_q;
    assign head_data  = e0_q;
    assign head_valid = (cnt_q != 2'd0);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: read pointer, array read issue, and a
// first-word-fall-through output stream behind a 2-entry skid buffer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = DEF_ADDR_W,
    parameter int unsigned RD_WIDTH       = 64,
    parameter int unsigned RD_IND         = 8,
    parameter int unsigned RD_L2          = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [RAM_ADDR_WIDTH:0]   wr_ptr,
    output logic [RAM_ADDR_WIDTH:0]   rd_ptr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RD_WIDTH-1:0]       ram_rd_data,
    output logic [RD_WIDTH-1:0]       m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      empty,
    output logic                      overflow
);

    localparam int unsigned PW = RAM_ADDR_WIDTH + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] occ;
    logic [PW-1:0] flush_ptr;
    logic          inflight_q, inflight_d;
    logic          ovf_q, ovf_d;
    logic          avail, pop, issue;
    logic [1:0]    count;
    logic [2:0]    slots;

    assign occ = PW'(ptr_occ(wide_ptr_t'(wr_ptr),
                             wide_ptr_t'(rd_ptr_q), PW));
    assign avail     = (occ >= PW'(RD_IND));
    assign pop       = m_valid & m_ready;
    assign flush_ptr = wr_ptr & ~PW'(RD_IND - 1);

    // Slots still committed after this cycle's pop; a read needs one free.
    assign slots = 3'(count) + 3'(inflight_q) - 3'(pop);
    assign issue = avail & ~flush & (slots < 3'd2);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        inflight_d = 1'b0;
        ovf_d      = ovf_q | (occ > (PW'(1) << RAM_ADDR_WIDTH));
        if (flush) begin
            rd_ptr_d = flush_ptr;
        end else if (issue) begin
            rd_ptr_d   = rd_ptr_q + PW'(RD_IND);
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
        end
    end

    rd_skid_buf #(
        .W(RD_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q & ~flush),
        .pop        (pop),
        .flush      (flush),
        .din        (ram_rd_data),
        .count      (count),
        .head_data  (m_data),
        .head_valid (m_valid)
    );

    assign rd_ptr      = rd_ptr_q;
    assign ram_rd_addr = rd_ptr_q[RAM_ADDR_WIDTH-1:0];
    assign overflow    = ovf_q;
    assign empty       = ~avail & ~inflight_q & (count == 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios then random traffic,
// checked against an in-order word stream model of the FIFO contents.
module tb_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic [6:0]  wr_ptr = '0;
    logic [6:0]  rd_ptr;
    logic [5:0]  ram_rd_addr;
    logic [63:0] ram_rd_data = '0;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        empty;
    logic        overflow;

    int          total = 0;
    int          bad = 0;
    logic [31:0] salt = 32'h1234_5678;
    logic [6:0]  exp_addr = '0;
    logic        pv = 1'b0, pr = 1'b0, pf = 1'b0;
    logic [63:0] pd = '0;
    logic [6:0]  fw = '0;

    fifo_rd_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_at(input logic [5:0] a);
        return {salt ^ {26'd0, a}, 2'b10, a, ~a, 2'b01, {10'd0, a}};
    endfunction

    // Storage array with one-cycle registered read.
    always @(posedge clk) ram_rd_data <= word_at(ram_rd_addr);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the cycle's outputs, advance the model.
    task automatic tick();
        logic [6:0] pend;
        @(negedge clk);
        pend = wr_ptr - exp_addr;
        chk("empty", 64'(empty), 64'(pend < 7'd8));
        if (pv && !pr && !pf) begin
            chk("hold_valid", 64'(m_valid), 64'd1);
            chk("hold_data", m_data, pd);
        end
        if (m_valid) chk("no_early", 64'(pend >= 7'd8), 64'd1);
        if (m_valid && m_ready) begin
            chk("data", m_data, word_at(exp_addr[5:0]));
            exp_addr = exp_addr + 7'd8;
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
        pf = flush;
        fw = wr_ptr;
        @(posedge clk);
        if (pf) exp_addr = {fw[6:3], 3'b000};
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        wr_ptr = '0;
        #2;
        chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
        chk("rst_addr", 64'(ram_rd_addr), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ovf", 64'(overflow), 64'd0);
        exp_addr = '0;
        pv = 1'b0;
        pf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        salt = $urandom;
        #1;
        do_reset();

        // Single word, first-word latency.
        wr_ptr = 7'd8;
        m_ready = 1'b1;
        #1;
        chk("sw_addr", 64'(ram_rd_addr), 64'd0);
        tick();
        chk("sw_rd_ptr", 64'(rd_ptr), 64'd8);
        chk("sw_valid_c1", 64'(m_valid), 64'd0);
        tick();
        chk("sw_valid_c2", 64'(m_valid), 64'd1);
        chk("sw_data", m_data, word_at(6'd0));
        tick();
        chk("sw_valid_c3", 64'(m_valid), 64'd0);
        chk("sw_empty", 64'(empty), 64'd1);

        // Backpressure: two issues then stall, then gapless drain.
        do_reset();
        wr_ptr = 7'd32;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_rd_ptr", 64'(rd_ptr), 64'd16);
        chk("bp_valid", 64'(m_valid), 64'd1);
        chk("bp_head", m_data, word_at(6'd0));
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_stream", 64'(m_valid), 64'd1);
            tick();
        end
        chk("bp_rd_end", 64'(rd_ptr), 64'd32);
        chk("bp_valid_end", 64'(m_valid), 64'd0);
        chk("bp_empty", 64'(empty), 64'd1);

        // Wrap-around of the 7-bit pointer.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr_ptr = wr_ptr + 7'd8;
            tick();
            tick();
        end
        for (int i = 0; i < 6; i++) tick();
        chk("wr_pre_rd", 64'(rd_ptr), 64'd120);
        chk("wr_pre_empty", 64'(empty), 64'd1);
        wr_ptr = 7'd8;
        #1;
        chk("wr_addr0", 64'(ram_rd_addr), 64'd56);
        tick();
        chk("wr_rd0", 64'(rd_ptr), 64'd0);
        chk("wr_addr1", 64'(ram_rd_addr), 64'd0);
        tick();
        chk("wr_rd1", 64'(rd_ptr), 64'd8);
        chk("wr_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) tick();

        // Partial word is never issued.
        wr_ptr = 7'd13;
        for (int i = 0; i < 4; i++) tick();
        chk("pw_rd", 64'(rd_ptr), 64'd8);
        chk("pw_valid", 64'(m_valid), 64'd0);
        chk("pw_empty", 64'(empty), 64'd1);

        // Flush with one word buffered and one in flight.
        m_ready = 1'b0;
        wr_ptr = 7'd29;
        tick();
        tick();
        chk("fl_pre_valid", 64'(m_valid), 64'd1);
        chk("fl_pre_rd", 64'(rd_ptr), 64'd24);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 64'(m_valid), 64'd0);
        chk("fl_rd", 64'(rd_ptr), 64'd24);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_ghost", 64'(m_valid), 64'd0);
        end

        // Sticky overflow.
        m_ready = 1'b0;
        wr_ptr = 7'd96;
        tick();
        chk("ov_set", 64'(overflow), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("ov_sticky", 64'(overflow), 64'd1);
        do_reset();

        // Random traffic within the array depth.
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            logic [6:0] nocc;
            m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            if (flush) m_ready = 1'b0;
            r = $urandom_range(0, 8);
            nocc = wr_ptr + 7'(r) - rd_ptr;
            if (nocc <= 7'd64) wr_ptr = wr_ptr + 7'(r);
            tick();
        end
        flush = 1'b0;
        chk("rnd_ovf", 64'(overflow), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
